// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz scan timing generator.
//   Divides clk into a one-cycle pixel tick and runs raw horizontal/vertical
//   scan counters covering the whole frame, including blanking.
// Ports:
//   clk        in   system clock, the only clock
//   reset      in   synchronous, active-high reset
//   hsync      out  horizontal sync, active low, registered
//   vsync      out  vertical sync, active low, registered
//   video_on   out  high while (x,y) lies in the visible area
//   p_tick     out  one-clk pulse every CLK_DIV clocks
//   x          out  horizontal scan counter, 0..H_TOTAL-1
//   y          out  vertical scan counter, 0..V_TOTAL-1
//   frame_end  out  high on the p_tick at which x,y wrap to 0,0
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_end
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // The counters are 10 bits wide; larger totals cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be at least 2");
  end

  logic [DIV_W-1:0] div;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             x_wrap;

  assign p_tick = (div == DIV_MAX);
  assign x_wrap = p_tick && (x == H_MAX);

  always_comb begin
    x_next = x;
    y_next = y;
    if (p_tick) begin
      x_next = x_wrap ? 10'd0 : x + 10'd1;
    end
    if (x_wrap) begin
      y_next = (y == V_MAX) ? 10'd0 : y + 10'd1;
    end
  end

  // Syncs are loaded from the next counter values so they change on the
  // same edge as x/y, with no one-pixel skew between sync and coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      div   <= '0;
      x     <= '0;
      y     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      div   <= p_tick ? '0 : div + DIV_W'(1);
      x     <= x_next;
      y     <= y_next;
      hsync <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
      vsync <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
    end
  end

  assign video_on  = (x < H_VIS) && (y < V_VIS);
  assign frame_end = x_wrap && (y == V_MAX);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-parameter instance (real 640x480 timing)
// and a shrunken-frame instance with CLK_DIV=2 so whole frames fit in a
// short run. Both share clk/reset and are compared every cycle against an
// arithmetic model: the pixel index since reset is clk_count / CLK_DIV.
module tb_vga_sync_gen;

  // shrunken frame: 30 x 15 scan, 2 clk per pixel
  localparam int SHD = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVD = 8,  SVF = 2, SVS = 2, SVB = 3;
  localparam int SCD = 2;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_end;
  } exp_t;

  typedef struct {
    longint n;
    exp_t   e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       f_hsync, f_vsync, f_video_on, f_p_tick, f_frame_end;
  logic [9:0] f_x, f_y;
  logic       s_hsync, s_vsync, s_video_on, s_p_tick, s_frame_end;
  logic [9:0] s_x, s_y;

  vga_sync_gen u_full (
    .clk(clk), .reset(reset), .hsync(f_hsync), .vsync(f_vsync),
    .video_on(f_video_on), .p_tick(f_p_tick), .x(f_x), .y(f_y),
    .frame_end(f_frame_end)
  );

  vga_sync_gen #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .CLK_DIV(SCD)
  ) u_small (
    .clk(clk), .reset(reset), .hsync(s_hsync), .vsync(s_vsync),
    .video_on(s_video_on), .p_tick(s_p_tick), .x(s_x), .y(s_y),
    .frame_end(s_frame_end)
  );

  int     vectors = 0;
  int     miscompares = 0;
  longint n_f = 0;
  longint n_s = 0;
  bit     armed = 1'b0;

  // clk cycles elapsed since the last edge that sampled reset high
  always @(posedge clk) begin
    if (reset) begin
      n_f   <= 0;
      n_s   <= 0;
      armed <= 1'b1;
    end else begin
      n_f <= n_f + 1;
      n_s <= n_s + 1;
    end
  end

  function automatic exp_t model(int hd, int hf, int hs, int hb, int vd, int vf,
                                 int vs, int vb, int cd, longint n);
    exp_t   e;
    int     ht = hd + hf + hs + hb;
    int     vt = vd + vf + vs + vb;
    longint p  = (n / cd) % (ht * vt);
    int     xi = int'(p % ht);
    int     yi = int'(p / ht);
    e.p_tick    = ((n % cd) == cd - 1);
    e.x         = 10'(xi);
    e.y         = 10'(yi);
    e.hsync     = !(xi >= hd + hf && xi < hd + hf + hs);
    e.vsync     = !(yi >= vd + vf && yi < vd + vf + vs);
    e.video_on  = (xi < hd) && (yi < vd);
    e.frame_end = e.p_tick && xi == ht - 1 && yi == vt - 1;
    return e;
  endfunction

  function automatic exp_t mk(logic p, int xv, int yv, logic h, logic v,
                              logic von, logic fe);
    exp_t e;
    e.p_tick = p; e.x = 10'(xv); e.y = 10'(yv); e.hsync = h; e.vsync = v;
    e.video_on = von; e.frame_end = fe;
    return e;
  endfunction

  task automatic cmp(string name, longint n, exp_t got, exp_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s n=%0d got p=%b x=%0d y=%0d hs=%b vs=%b von=%b fe=%b expected p=%b x=%0d y=%0d hs=%b vs=%b von=%b fe=%b",
               name, n, got.p_tick, got.x, got.y, got.hsync, got.vsync, got.video_on, got.frame_end,
               want.p_tick, want.x, want.y, want.hsync, want.vsync, want.video_on, want.frame_end);
    end
  endtask

  task automatic chk(string name, longint got, longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  // continuous model comparison for both instances
  always @(negedge clk) begin
    if (armed) begin
      cmp("full_model", n_f,
          {f_p_tick, f_x, f_y, f_hsync, f_vsync, f_video_on, f_frame_end},
          model(640, 16, 96, 48, 480, 10, 2, 33, 4, n_f));
      cmp("small_model", n_s,
          {s_p_tick, s_x, s_y, s_hsync, s_vsync, s_video_on, s_frame_end},
          model(SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, SCD, n_s));
    end
  end

  task automatic do_reset(int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t   tbl[12];
  int     fe_cnt, rp_cnt, vs_low;
  longint first_fe, rp_prev;
  bit     found;

  initial begin
    // expected values for the default instance, written out by hand
    tbl[0]  = '{0,    mk(0, 0,   0, 1, 1, 1, 0)};
    tbl[1]  = '{3,    mk(1, 0,   0, 1, 1, 1, 0)};
    tbl[2]  = '{4,    mk(0, 1,   0, 1, 1, 1, 0)};
    tbl[3]  = '{2559, mk(1, 639, 0, 1, 1, 1, 0)};
    tbl[4]  = '{2560, mk(0, 640, 0, 1, 1, 0, 0)};
    tbl[5]  = '{2623, mk(1, 655, 0, 1, 1, 0, 0)};
    tbl[6]  = '{2624, mk(0, 656, 0, 0, 1, 0, 0)};
    tbl[7]  = '{3007, mk(1, 751, 0, 0, 1, 0, 0)};
    tbl[8]  = '{3008, mk(0, 752, 0, 1, 1, 0, 0)};
    tbl[9]  = '{3199, mk(1, 799, 0, 1, 1, 0, 0)};
    tbl[10] = '{3200, mk(0, 0,   1, 1, 1, 1, 0)};
    tbl[11] = '{3203, mk(1, 0,   1, 1, 1, 1, 0)};

    @(negedge clk);
    do_reset(3);
    for (int i = 0; i < 12; i++) begin
      for (int b = 0; b < 4000 && n_f < tbl[i].n; b++) @(negedge clk);
      cmp($sformatf("line_vec%0d", i), n_f,
          {f_p_tick, f_x, f_y, f_hsync, f_vsync, f_video_on, f_frame_end}, tbl[i].e);
    end

    // three small frames: frame_end, refresh point y=9,x=0, vsync length
    do_reset(2);
    fe_cnt = 0; rp_cnt = 0; vs_low = 0; first_fe = -1; rp_prev = -1;
    for (int i = 0; i < 2700; i++) begin
      if (s_frame_end) begin
        fe_cnt++;
        if (first_fe < 0) first_fe = n_s;
      end
      if (s_y == 10'd9 && s_x == 10'd0 && s_p_tick) begin
        if (rp_prev >= 0) chk("refresh_spacing", n_s - rp_prev, 900);
        rp_prev = n_s;
        rp_cnt++;
      end
      if (i < 900 && !s_vsync) vs_low++;
      @(negedge clk);
    end
    chk("frame_end_count", fe_cnt, 3);
    chk("first_frame_end_n", first_fe, 899);
    chk("refresh_count", rp_cnt, 3);
    chk("vsync_low_clks", vs_low, 120);

    // reset while both syncs are low on the small instance
    found = 1'b0;
    for (int b = 0; b < 2000 && !found; b++) begin
      if (s_x == 10'd22 && s_y == 10'd11) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_x22_y11", found, 1);
    chk("mid_sync_hsync_low", s_hsync, 0);
    chk("mid_sync_vsync_low", s_vsync, 0);
    do_reset(1);
    chk("after_rst_hsync", s_hsync, 1);
    chk("after_rst_vsync", s_vsync, 1);
    chk("after_rst_x", s_x, 0);
    chk("after_rst_y", s_y, 0);
    fe_cnt = 0;
    first_fe = -1;
    for (int i = 0; i < 900; i++) begin
      if (s_frame_end) begin
        fe_cnt++;
        first_fe = n_s;
      end
      @(negedge clk);
    end
    chk("refr_frame_end_count", fe_cnt, 1);
    chk("refr_frame_end_n", first_fe, 899);

    // random run lengths with random reset pulses; the model checks every cycle
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(1, 1500)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) do_reset(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the 640x480@60 Hz display path. It divides the system clock into a pixel tick and runs horizontal and vertical scan counters. It produces active-low hsync/vsync to the connector, plus `x`, `y` and `video_on` for the pixel generator. `x`/`y` are raw scan counters covering the full frame including blanking, so downstream logic can key events on off-screen coordinates such as the refresh point y=481, x=0.

## Interface
- `H_DISPLAY`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_DISPLAY`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `CLK_DIV`, 4: system clocks per pixel (≥2)
- `clk` input 1: system clock (100 MHz); the block's only clock
- `reset` input 1: synchronous, active-high reset
- `hsync` output 1: horizontal sync, active low, registered
- `vsync` output 1: vertical sync, active low, registered
- `video_on` output 1: high while (`x`,`y`) is in the visible area
- `p_tick` output 1: one-`clk` pulse every `CLK_DIV` clocks
- `x` output 10: horizontal counter, 0..H_TOTAL-1
- `y` output 10: vertical counter, 0..V_TOTAL-1
- `frame_end` output 1: pulse on the `p_tick` at which `x`,`y` wrap to 0,0

## Operation
- Derived: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Divider: `div` counts 0..CLK_DIV-1 and wraps; `p_tick` = (`div` == CLK_DIV-1), combinational from the register.
- H counter: on a clk edge with `p_tick`=1, `x` increments. It wraps to 0 when `x` == H_TOTAL-1.
- V counter: advances only on the same edge where `x` wraps. `y` increments and wraps to 0 when `y` == V_TOTAL-1.
- `x` and `y` never hold values ≥ H_TOTAL or ≥ V_TOTAL. Counter width is 10 bits; the implementation asserts the totals are ≤1024.
- `hsync` register: loaded from the next counter value, so `hsync`=0 exactly while `x` is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
- `vsync` register: same scheme; `vsync`=0 exactly while `y` is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- `video_on` = (`x` < H_DISPLAY) && (`y` < V_DISPLAY), combinational from the registered counters.
- `frame_end` = `p_tick` && `x`==H_TOTAL-1 && `y`==V_TOTAL-1.

## Timing
- Reset values, at the first edge with `reset`=1: `div`=0, `x`=0, `y`=0, `hsync`=1, `vsync`=1.
- Resulting outputs after reset: `p_tick`=0, `video_on`=1, `frame_end`=0.
- Reset dominates everything. Asserting it mid-line or mid-sync pulse returns all registers to their reset values on that edge, and the frame restarts from 0,0.
- After reset release, the first `p_tick` is high during the CLK_DIV-th clk cycle. `x` becomes 1 on that cycle's closing edge.
- `x`, `y`, `hsync` and `vsync` change only on edges where `p_tick`=1, and all four change on the same edge. There is no skew between sync and coordinates.
- Line period is H_TOTAL·CLK_DIV clk (3200). Frame period is H_TOTAL·V_TOTAL·CLK_DIV clk (1,680,000), which is 59.52 Hz at 100 MHz.
- Simultaneous wrap of `x` and `y`: both reach 0 on the same edge, and `frame_end` is high on the cycle before that edge.
- Each (`x`,`y`) value, including 0,481, is held for exactly CLK_DIV clk cycles, once per frame.

## Test plan
- Reset: hold `reset` for 3 cycles, then release → `x`=0, `y`=0, `hsync`=1, `vsync`=1, `video_on`=1; `p_tick` high only on cycles 4, 8, 12, … after release.
- Horizontal window: run one line → `hsync` falls as `x` goes 655→656 and rises as 751→752; `video_on` falls as `x` goes 639→640; `x` wraps 799→0 and `y` goes 0→1 on the same edge.
- Vertical window/wrap: run one full frame → `vsync` low only for `y`=490..491 (2 lines = 6400 clk); `video_on`=0 for all `y`≥480; exactly one `frame_end` pulse, after 1,680,000 clk.
- Refresh point: count cycles with `y`==481 && `x`==0 && `p_tick` over 3 frames → exactly 3, spaced 420,000 `p_tick`s apart.
- Reset mid-sync: assert `reset` for 1 cycle while `x`=700, `y`=491 (both syncs low) → on the next cycle `hsync`=`vsync`=1, `x`=`y`=0, and the full-frame check passes again.
- Parameter override: `CLK_DIV`=2 → `p_tick` every 2 clk, line = 1600 clk, sync windows unchanged in `x`/`y` terms.
